ofs_fim_eth_tx_axis_arb: RTL and testbench
==========================================

OFS_FIM_ETH_TX_AXIS_ARB -- requirements
Module: ofs_fim_eth_tx_axis_arb

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of AFU-side TX requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 64, tdata width in bits (multiple of 8).
REQ-003 Parameter USER_WIDTH, default 8, tuser width in bits.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  reset, asynchronous assert, active-high.
REQ-006 in_tvalid  input  NUM_PORTS  per-port beat valid.
REQ-007 in_tready  output  NUM_PORTS  per-port beat ready.
REQ-008 in_tdata  input  NUM_PORTS*DATA_WIDTH  port p at slice [p*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_tkeep  input  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
REQ-010 in_tlast  input  NUM_PORTS  per-port end of packet.
REQ-011 in_tuser  input  NUM_PORTS*USER_WIDTH  per-port sideband.
REQ-012 out_tvalid, out_tdata, out_tkeep, out_tlast, out_tuser  output  widths as single port  FIM-side TX stream.
REQ-013 out_tready  input  1  FIM-side ready.
REQ-014 grant_idx  output  $clog2(NUM_PORTS)  port currently owning the output.
REQ-015 busy  output  1  high while a packet is in progress (state PKT).
REQ-016 pkt_cnt  output  16  count of packets forwarded (tlast beats accepted at output), wraps.

Function
REQ-017 The block SHALL share one FIM TX AXI-S channel among NUM_PORTS requesters at packet granularity; beats of different packets never interleave.
REQ-018 FSM states: IDLE, PKT.
REQ-019 IDLE: if any in_tvalid, next cycle grant_idx <= first asserted port searching upward from rr_ptr with wrap, state -> PKT; else stay.
REQ-020 IDLE: in_tready all 0; one-cycle arbitration bubble per packet.
REQ-021 PKT: in_tready[grant_idx] = (!out_tvalid || out_tready); all other in_tready bits 0.
REQ-022 Output register: single stage; loads granted port's tdata/tkeep/tlast/tuser when in_tvalid[grant_idx] && in_tready[grant_idx]; out_tvalid cleared when out_tready and no new load.
REQ-023 Full throughput: back-to-back beats of one packet at 1 beat/clk when out_tready stays high.
REQ-024 out_* payload SHALL hold stable while out_tvalid && !out_tready.
REQ-025 PKT: accepted input beat with tlast -> state IDLE, rr_ptr <= (grant_idx+1) mod NUM_PORTS, same cycle.
REQ-026 A single-beat packet (tlast on first beat) SHALL be handled identically.
REQ-027 Requester dropping tvalid mid-packet: grant held, no timeout, arbiter waits.
REQ-028 pkt_cnt increments by 1 when out_tvalid && out_tready && out_tlast; 0xFFFF wraps to 0x0000.
REQ-029 grant_idx changes only on IDLE->PKT transition.
REQ-030 busy = (state == PKT).

Reset
REQ-031 rst SHALL asynchronously force: state IDLE, rr_ptr 0, grant_idx 0, out_tvalid 0, in_tready 0, busy 0, pkt_cnt 0; payload registers don't-care.
REQ-032 Reset mid-packet SHALL discard the partial packet; first post-reset grant goes to lowest-index valid port.
REQ-033 Outputs SHALL be deterministic on the first clk edge after rst deassertion.

Verification
REQ-034 All ports valid with 1-beat packets, out_tready=1 -> output order 0,1,2,3,0,...; one bubble between packets; pkt_cnt=8 after 8 packets.
REQ-035 Port 2 sends 4-beat packet while port 0 valid from cycle 1 -> all 4 port-2 beats contiguous, then port 0 granted; grant_idx=2 throughout.
REQ-036 out_tready toggles 1,0,1,0 during 3-beat packet -> payload stable while stalled, beats in order, no loss or duplication.
REQ-037 rst asserted on beat 2 of 5-beat packet from port 1 -> out_tvalid=0, busy=0 immediately; after release, ports 1 and 3 valid -> port 1 granted (rr_ptr=0).
REQ-038 Drive 65537 single-beat packets -> pkt_cnt=0x0001 (wrap).
REQ-039 Only port 3 valid repeatedly -> port 3 regranted each packet; rr_ptr wraps 3->0.

Source files
------------

// File: rtl/ofs_fim_eth_tx_axis_arb.sv
// ---------------------------------------------------------------------------
// ofs_fim_eth_tx_axis_arb
//
// Packet-granular round-robin arbiter that shares one FIM-side TX AXI-Stream
// channel among NUM_PORTS AFU-side requesters. Once a port is granted, it owns
// the output until its tlast beat is accepted, so packets never interleave.
// Each packet costs one arbitration cycle in IDLE. After that, its beats flow
// at one per clock through a single output register stage.
//
// Handshake: a beat transfers on a clock edge where tvalid && tready are both
// high. A source must hold tvalid and its payload until that edge. Readiness
// never depends on tvalid in the same cycle.
//
// Parameters
//   NUM_PORTS  : number of requesters (2..8)
//   DATA_WIDTH : tdata width in bits (multiple of 8)
//   USER_WIDTH : tuser width in bits
//   CNT_WIDTH  : width of the forwarded-packet counter (16 by default)
//
// Ports
//   clk, rst     : single clock; asynchronous active-high reset
//   in_tvalid    : per-port beat valid
//   in_tready    : per-port beat ready (only the granted port, only in PKT)
//   in_tdata     : port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_tkeep     : port p at [p*DATA_WIDTH/8 +: DATA_WIDTH/8]
//   in_tlast     : per-port end of packet
//   in_tuser     : port p at [p*USER_WIDTH +: USER_WIDTH]
//   out_t*       : FIM-side TX stream (registered)
//   out_tready   : FIM-side ready
//   grant_idx    : port currently owning the output
//   busy         : FSM state, high while in PKT
//   pkt_cnt      : packets forwarded (tlast beats accepted at output), wraps
// ---------------------------------------------------------------------------
module ofs_fim_eth_tx_axis_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int GW         = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  in_tkeep,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  in_tuser,
  output logic                             out_tvalid,
  output logic [DATA_WIDTH-1:0]            out_tdata,
  output logic [KEEP_WIDTH-1:0]            out_tkeep,
  output logic                             out_tlast,
  output logic [USER_WIDTH-1:0]            out_tuser,
  input  logic                             out_tready,
  output logic [GW-1:0]                    grant_idx,
  output logic                             busy,
  output logic [CNT_WIDTH-1:0]             pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_PORTS - 1);

  state_t                  state_q, state_d;
  logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic                    out_tvalid_q, out_tvalid_d;
  logic [DATA_WIDTH-1:0]   out_tdata_q, out_tdata_d;
  logic [KEEP_WIDTH-1:0]   out_tkeep_q, out_tkeep_d;
  logic                    out_tlast_q, out_tlast_d;
  logic [USER_WIDTH-1:0]   out_tuser_q, out_tuser_d;
  logic [CNT_WIDTH-1:0]    pkt_cnt_q, pkt_cnt_d;

  // Granted port's input stream, muxed by the registered grant.
  logic                    sel_tvalid;
  logic [DATA_WIDTH-1:0]   sel_tdata;
  logic [KEEP_WIDTH-1:0]   sel_tkeep;
  logic                    sel_tlast;
  logic [USER_WIDTH-1:0]   sel_tuser;

  // Round-robin search result.
  logic                    arb_found;
  logic [GW-1:0]           arb_idx;
  logic [GW-1:0]           cand;

  logic                    beat_ready;
  logic                    beat_acc;

  always_comb begin
    sel_tvalid = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    sel_tuser  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == GW'(p)) begin
        sel_tvalid = in_tvalid[p];
        sel_tdata  = in_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep  = in_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tlast  = in_tlast[p];
        sel_tuser  = in_tuser[p*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // Walk upward from rr_ptr with wrap; the first valid port wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!arb_found && in_tvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    in_tready    = '0;
    out_tvalid_d = out_tvalid_q;
    out_tdata_d  = out_tdata_q;
    out_tkeep_d  = out_tkeep_q;
    out_tlast_d  = out_tlast_q;
    out_tuser_d  = out_tuser_q;
    pkt_cnt_d    = pkt_cnt_q;
    beat_acc     = 1'b0;
    // The output register can take a beat when empty or draining this cycle.
    beat_ready   = !out_tvalid_q || out_tready;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = PKT;
        end
      end
      PKT: begin
        in_tready[grant_q] = beat_ready;
        beat_acc           = sel_tvalid && beat_ready;
        if (beat_acc && sel_tlast) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (beat_acc) begin
      out_tvalid_d = 1'b1;
      out_tdata_d  = sel_tdata;
      out_tkeep_d  = sel_tkeep;
      out_tlast_d  = sel_tlast;
      out_tuser_d  = sel_tuser;
    end else if (out_tready) begin
      out_tvalid_d = 1'b0;
    end

    if (out_tvalid_q && out_tready && out_tlast_q) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      out_tvalid_q <= 1'b0;
      out_tdata_q  <= '0;
      out_tkeep_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      out_tvalid_q <= out_tvalid_d;
      out_tdata_q  <= out_tdata_d;
      out_tkeep_q  <= out_tkeep_d;
      out_tlast_q  <= out_tlast_d;
      out_tuser_q  <= out_tuser_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign out_tvalid = out_tvalid_q;
  assign out_tdata  = out_tdata_q;
  assign out_tkeep  = out_tkeep_q;
  assign out_tlast  = out_tlast_q;
  assign out_tuser  = out_tuser_q;
  assign grant_idx  = grant_q;
  assign busy       = (state_q == PKT);
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_ofs_fim_eth_tx_axis_arb.sv
module tb_ofs_fim_eth_tx_axis_arb;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int UW = 8;
  localparam int KW = DW / 8;
  localparam int GW = 2;
  localparam int CW = 8;   // narrow counter so the wrap is reachable quickly
  localparam int BW = UW + KW + 1 + DW;

  typedef struct packed {
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    in_tvalid = '0;
  logic [NP-1:0]    in_tready;
  logic [NP*DW-1:0] in_tdata = '0;
  logic [NP*KW-1:0] in_tkeep = '0;
  logic [NP-1:0]    in_tlast = '0;
  logic [NP*UW-1:0] in_tuser = '0;
  logic             out_tvalid;
  logic [DW-1:0]    out_tdata;
  logic [KW-1:0]    out_tkeep;
  logic             out_tlast;
  logic [UW-1:0]    out_tuser;
  logic             out_tready = 1'b1;
  logic [GW-1:0]    grant_idx;
  logic             busy;
  logic [CW-1:0]    pkt_cnt;

  always #5 clk = ~clk;

  ofs_fim_eth_tx_axis_arb #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .in_tkeep  (in_tkeep),
    .in_tlast  (in_tlast),
    .in_tuser  (in_tuser),
    .out_tvalid(out_tvalid),
    .out_tdata (out_tdata),
    .out_tkeep (out_tkeep),
    .out_tlast (out_tlast),
    .out_tuser (out_tuser),
    .out_tready(out_tready),
    .grant_idx (grant_idx),
    .busy      (busy),
    .pkt_cnt   (pkt_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- source drivers ----------------
  logic [BW-1:0] src_q[NP][$];
  logic [NP-1:0] fire_n = '0;
  beat_t         hb;

  // Transfers are decided at the negedge, where everything has settled.
  always @(negedge clk) fire_n = rst ? '0 : (in_tvalid & in_tready);

  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (fire_n[p] && src_q[p].size() > 0) src_q[p].delete(0);
      if (src_q[p].size() > 0) begin
        hb = src_q[p][0];
        in_tvalid[p]            = 1'b1;
        in_tdata[p*DW +: DW]    = hb.data;
        in_tkeep[p*KW +: KW]    = hb.keep;
        in_tlast[p]             = hb.last;
        in_tuser[p*UW +: UW]    = hb.user;
      end else begin
        in_tvalid[p] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] obs_q[$];
  int            obs_cyc[$];
  logic [GW-1:0] obs_gnt[$];

  always @(negedge clk) begin
    if (!rst && out_tvalid && out_tready) begin
      obs_q.push_back({out_tuser, out_tkeep, out_tlast, out_tdata});
      obs_cyc.push_back(cyc);
      obs_gnt.push_back(grant_idx);
    end
  end

  function automatic logic [BW-1:0] mk(input int port, input int seq, input int idx, input bit last);
    beat_t b;
    b.data = {8'(port), 8'hA5, 16'(seq), 16'(idx), 16'hBEEF};
    b.keep = {KW{1'b1}} >> idx;
    b.user = {4'(port), 4'(idx)};
    b.last = last;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    obs_gnt.delete();
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (obs_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    ok = (obs_q.size() >= n);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    out_tready = 1'b1;
    repeat (3) tick();
    n_checks++; if (out_tvalid !== 1'b0) $display("FAIL reset_out_tvalid: got %b expected 0", out_tvalid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (grant_idx !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", grant_idx); else n_pass++;
    n_checks++; if (pkt_cnt !== 8'd0) $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); else n_pass++;
    n_checks++; if (in_tready !== 4'b0000) $display("FAIL reset_in_tready: got %b expected 0000", in_tready); else n_pass++;
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (out_tvalid !== 1'b0) $display("FAIL post_reset_out_tvalid: got %b expected 0", out_tvalid); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    clear_sb();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) begin
        src_q[p].push_back(mk(p, k, 0, 1'b1));
        exp_q.push_back(mk(p, k, 0, 1'b1));
      end
    wait_beats(8, 100, ok);
    n_checks++; if (!ok) $display("FAIL rr_timeout: got %0d beats expected 8", obs_q.size()); else n_pass++;
    tick();
    tick();
    n_checks++; if (obs_q.size() != 8) $display("FAIL rr_count: got %0d expected 8", obs_q.size()); else n_pass++;
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rr_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (obs_gnt[i] !== 2'(i % NP)) $display("FAIL rr_grant%0d: got %0d expected %0d", i, obs_gnt[i], i % NP); else n_pass++;
    end
    for (int i = 1; i < 8 && i < obs_cyc.size(); i++) begin
      n_checks++; if (obs_cyc[i] - obs_cyc[i-1] != 2) $display("FAIL rr_spacing%0d: got %0d expected 2", i, obs_cyc[i] - obs_cyc[i-1]); else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 8'd8) $display("FAIL rr_pkt_cnt: got %0d expected 8", pkt_cnt); else n_pass++;
  endtask

  task automatic test_hold_packet();
    bit ok;
    logic [GW-1:0] exp_gnt[5];
    exp_gnt = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    clear_sb();
    for (int b = 0; b < 4; b++) begin
      src_q[2].push_back(mk(2, 10, b, b == 3));
      exp_q.push_back(mk(2, 10, b, b == 3));
    end
    exp_q.push_back(mk(0, 11, 0, 1'b1));
    tick();
    src_q[0].push_back(mk(0, 11, 0, 1'b1));
    tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL hold_busy: got %b expected 1", busy); else n_pass++;
    n_checks++; if (grant_idx !== 2'd2) $display("FAIL hold_grant: got %0d expected 2", grant_idx); else n_pass++;
    n_checks++; if (in_tready !== 4'b0100) $display("FAIL hold_in_tready: got %b expected 0100", in_tready); else n_pass++;
    wait_beats(5, 50, ok);
    n_checks++; if (!ok) $display("FAIL hold_timeout: got %0d beats expected 5", obs_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL hold_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (obs_gnt[i] !== exp_gnt[i]) $display("FAIL hold_grant%0d: got %0d expected %0d", i, obs_gnt[i], exp_gnt[i]); else n_pass++;
    end
    for (int i = 1; i < 4 && i < obs_cyc.size(); i++) begin
      n_checks++; if (obs_cyc[i] - obs_cyc[i-1] != 1) $display("FAIL hold_contig%0d: got %0d expected 1", i, obs_cyc[i] - obs_cyc[i-1]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stalled;
    logic [BW-1:0] held;
    clear_sb();
    stalled = 1'b0;
    held = '0;
    for (int b = 0; b < 3; b++) begin
      src_q[1].push_back(mk(1, 20, b, b == 2));
      exp_q.push_back(mk(1, 20, b, b == 2));
    end
    for (int c = 0; c < 16; c++) begin
      tick();
      if (stalled) begin
        n_checks++;
        if ({out_tuser, out_tkeep, out_tlast, out_tdata} !== held)
          $display("FAIL stall_hold_c%0d: got %h expected %h", c, {out_tuser, out_tkeep, out_tlast, out_tdata}, held);
        else n_pass++;
      end
      out_tready = (c % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      stalled = out_tvalid && !out_tready;
      held = {out_tuser, out_tkeep, out_tlast, out_tdata};
    end
    out_tready = 1'b1;
    wait_beats(3, 20, ok);
    n_checks++; if (!ok) $display("FAIL stall_timeout: got %0d beats expected 3", obs_q.size()); else n_pass++;
    tick();
    tick();
    n_checks++; if (obs_q.size() != 3) $display("FAIL stall_count: got %0d expected 3", obs_q.size()); else n_pass++;
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL stall_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 8'd11) $display("FAIL stall_pkt_cnt: got %0d expected 11", pkt_cnt); else n_pass++;
  endtask

  task automatic test_drop_valid();
    bit ok;
    clear_sb();
    exp_q.push_back(mk(0, 30, 0, 1'b0));
    exp_q.push_back(mk(0, 30, 1, 1'b0));
    exp_q.push_back(mk(0, 30, 2, 1'b1));
    exp_q.push_back(mk(3, 31, 0, 1'b1));
    src_q[0].push_back(mk(0, 30, 0, 1'b0));
    repeat (3) tick();
    src_q[3].push_back(mk(3, 31, 0, 1'b1));
    repeat (4) tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL drop_busy: got %b expected 1", busy); else n_pass++;
    n_checks++; if (grant_idx !== 2'd0) $display("FAIL drop_grant: got %0d expected 0", grant_idx); else n_pass++;
    n_checks++; if (in_tready !== 4'b0001) $display("FAIL drop_in_tready: got %b expected 0001", in_tready); else n_pass++;
    n_checks++; if (out_tvalid !== 1'b0) $display("FAIL drop_out_tvalid: got %b expected 0", out_tvalid); else n_pass++;
    src_q[0].push_back(mk(0, 30, 1, 1'b0));
    tick();
    src_q[0].push_back(mk(0, 30, 2, 1'b1));
    wait_beats(4, 50, ok);
    n_checks++; if (!ok) $display("FAIL drop_timeout: got %0d beats expected 4", obs_q.size()); else n_pass++;
    tick();
    tick();
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL drop_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 8'd13) $display("FAIL drop_pkt_cnt: got %0d expected 13", pkt_cnt); else n_pass++;
  endtask

  task automatic test_single_port();
    bit ok;
    clear_sb();
    for (int k = 0; k < 3; k++) begin
      src_q[3].push_back(mk(3, 40 + k, 0, 1'b1));
      exp_q.push_back(mk(3, 40 + k, 0, 1'b1));
    end
    wait_beats(3, 30, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: got %0d beats expected 3", obs_q.size()); else n_pass++;
    tick();
    tick();
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL single_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (obs_gnt[i] !== 2'd3) $display("FAIL single_grant%0d: got %0d expected 3", i, obs_gnt[i]); else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 8'd16) $display("FAIL single_pkt_cnt: got %0d expected 16", pkt_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_sb();
    for (int b = 0; b < 5; b++) src_q[1].push_back(mk(1, 50, b, b == 4));
    wait_beats(2, 30, ok);
    n_checks++; if (!ok) $display("FAIL rstmid_timeout: got %0d beats expected 2", obs_q.size()); else n_pass++;
    #1;
    rst = 1'b1;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    #1;
    n_checks++; if (out_tvalid !== 1'b0) $display("FAIL rstmid_out_tvalid: got %b expected 0", out_tvalid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (in_tready !== 4'b0000) $display("FAIL rstmid_in_tready: got %b expected 0000", in_tready); else n_pass++;
    n_checks++; if (pkt_cnt !== 8'd0) $display("FAIL rstmid_pkt_cnt: got %0d expected 0", pkt_cnt); else n_pass++;
    n_checks++; if (grant_idx !== 2'd0) $display("FAIL rstmid_grant: got %0d expected 0", grant_idx); else n_pass++;
    tick();
    tick();
    clear_sb();
    rst = 1'b0;
    src_q[1].push_back(mk(1, 51, 0, 1'b1));
    src_q[3].push_back(mk(3, 52, 0, 1'b1));
    exp_q.push_back(mk(1, 51, 0, 1'b1));
    exp_q.push_back(mk(3, 52, 0, 1'b1));
    wait_beats(2, 30, ok);
    n_checks++; if (!ok) $display("FAIL rstmid_post_timeout: got %0d beats expected 2", obs_q.size()); else n_pass++;
    tick();
    tick();
    n_checks++; if (obs_q.size() != 2) $display("FAIL rstmid_count: got %0d expected 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid_beat%0d: got %h expected %h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (pkt_cnt !== 8'd2) $display("FAIL rstmid_pkt_cnt_after: got %0d expected 2", pkt_cnt); else n_pass++;
  endtask

  task automatic test_cnt_wrap();
    bit ok;
    clear_sb();
    for (int i = 0; i < 253; i++) src_q[i % NP].push_back(mk(i % NP, 100 + i, 0, 1'b1));
    wait_beats(253, 800, ok);
    n_checks++; if (!ok) $display("FAIL wrap_timeout: got %0d beats expected 253", obs_q.size()); else n_pass++;
    tick();
    tick();
    n_checks++; if (pkt_cnt !== 8'hFF) $display("FAIL wrap_pkt_cnt_max: got %h expected ff", pkt_cnt); else n_pass++;
    src_q[2].push_back(mk(2, 400, 0, 1'b1));
    src_q[2].push_back(mk(2, 401, 0, 1'b1));
    wait_beats(255, 30, ok);
    n_checks++; if (!ok) $display("FAIL wrap_timeout2: got %0d beats expected 255", obs_q.size()); else n_pass++;
    tick();
    tick();
    n_checks++; if (pkt_cnt !== 8'h01) $display("FAIL wrap_pkt_cnt: got %h expected 01", pkt_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_hold_packet();
    test_stall();
    test_drop_valid();
    test_single_port();
    test_reset_mid();
    test_cnt_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
